// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage
//   Instruction-fetch stage of the pipelined MIPS core. It owns the PC and
//   drives the instruction-memory address. It registers the fetched word and
//   PC+4 into the IF/ID register. It applies jump/branch redirects and the
//   hazard unit's stall and flush controls. It also counts the instructions
//   accepted into IF/ID.
//
// Ports
//   clk, rst          core clock (rising edge), async active-high reset
//   instr_f           word read combinationally from imem at pc_f
//   stall_f           hold PC
//   stall_d           hold IF/ID register
//   flush_d           clear IF/ID to a bubble (wins over stall_d)
//   branch_taken_d    decode resolved a taken branch to pc_branch_d
//   pc_branch_d       branch target
//   jump_d            decode holds j/jal; target built from instr_d/pc_plus4_d
//   pc_f              current PC / imem address
//   instr_d           IF/ID instruction
//   pc_plus4_d        IF/ID PC+4
//   valid_d           instr_d is a real fetch, not a bubble
//   fetch_count       instructions accepted into IF/ID (wraps at 2^32)
//   misalign_err      sticky: a taken branch target had bits [1:0] != 0
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_f,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        branch_taken_d,
  input  logic [31:0] pc_branch_d,
  input  logic        jump_d,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [31:0] fetch_count,
  output logic        misalign_err
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d_n;
  logic [31:0] pc_plus4_q, pc_plus4_n;
  logic        valid_q, valid_n;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        misalign_q, misalign_d;
  logic [31:0] pc_plus4_f;

  assign pc_plus4_f = pc_q + 32'd4;

  // Next-PC select. A stalled fetch ignores redirects: the hazard unit keeps
  // them asserted until decode is released. The jump target comes from the
  // IF/ID register, so it has no combinational input path.
  always_comb begin
    pc_d       = pc_plus4_f;
    misalign_d = misalign_q;
    if (stall_f) begin
      pc_d = pc_q;
    end else if (jump_d) begin
      pc_d = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
    end else if (branch_taken_d) begin
      pc_d = {pc_branch_d[31:2], 2'b00};
      if (pc_branch_d[1:0] != 2'b00) misalign_d = 1'b1;
    end
  end

  // IF/ID register: flush beats stall, and only a real load is counted.
  always_comb begin
    instr_d_n     = instr_q;
    pc_plus4_n    = pc_plus4_q;
    valid_n       = valid_q;
    fetch_count_d = fetch_count_q;
    if (flush_d) begin
      instr_d_n  = NOP_INSTR;
      pc_plus4_n = 32'd0;
      valid_n    = 1'b0;
    end else if (!stall_d) begin
      instr_d_n     = instr_f;
      pc_plus4_n    = pc_plus4_f;
      valid_n       = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      pc_plus4_q    <= 32'd0;
      valid_q       <= 1'b0;
      fetch_count_q <= 32'd0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d_n;
      pc_plus4_q    <= pc_plus4_n;
      valid_q       <= valid_n;
      fetch_count_q <= fetch_count_d;
      misalign_q    <= misalign_d;
    end
  end

  assign pc_f         = pc_q;
  assign instr_d      = instr_q;
  assign pc_plus4_d   = pc_plus4_q;
  assign valid_d      = valid_q;
  assign fetch_count  = fetch_count_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
module tb_mips_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_f;
  logic        stall_f, stall_d, flush_d, branch_taken_d, jump_d;
  logic [31:0] pc_branch_d;
  logic [31:0] pc_f, instr_d, pc_plus4_d, fetch_count;
  logic        valid_d, misalign_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: what the fetch stage should hold after each edge.
  logic [31:0] m_pc, m_instr, m_p4, m_cnt;
  logic        m_valid, m_err;

  mips_fetch_stage dut (
    .clk(clk), .rst(rst), .instr_f(instr_f),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .branch_taken_d(branch_taken_d), .pc_branch_d(pc_branch_d), .jump_d(jump_d),
    .pc_f(pc_f), .instr_d(instr_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
    .fetch_count(fetch_count), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Instruction ROM: a small program at 0, a jump word at 0x1000_0010,
  // and a hash of the address everywhere else.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom = 32'h2008_0005;
      32'h0000_0004: rom = 32'h2009_0003;
      32'h0000_0008: rom = 32'h0109_5020;
      32'h0000_000C: rom = 32'hAC0A_0000;
      32'h1000_0010: rom = 32'h0800_0020;
      default:       rom = (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endcase
  endfunction

  always_comb instr_f = rom(pc_f);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"},    pc_f,         m_pc);
    chk({tag, ".instr"}, instr_d,      m_instr);
    chk({tag, ".p4"},    pc_plus4_d,   m_p4);
    chk({tag, ".vld"},   32'(valid_d), 32'(m_valid));
    chk({tag, ".cnt"},   fetch_count,  m_cnt);
    chk({tag, ".err"},   32'(misalign_err), 32'(m_err));
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0;
    m_valid = 1'b0; m_cnt = 32'h0; m_err = 1'b0;
  endtask

  // One clock with the given controls. The model advances from the pre-edge
  // state, and the outputs are checked 1ns after the edge.
  task automatic cyc(input logic sf, input logic sd, input logic fl,
                     input logic br, input logic [31:0] tgt, input logic jp,
                     input string tag);
    logic [31:0] npc, fetched;
    stall_f = sf; stall_d = sd; flush_d = fl;
    branch_taken_d = br; pc_branch_d = tgt; jump_d = jp;
    fetched = rom(m_pc);
    npc = m_pc;
    if (!sf) begin
      if (jp)      npc = {m_p4[31:28], m_instr[25:0], 2'b00};
      else if (br) begin
        npc = tgt & ~32'd3;
        if (tgt % 4 != 0) m_err = 1'b1;
      end
      else         npc = m_pc + 32'd4;
    end
    @(posedge clk);
    if (fl) begin
      m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0;
    end else if (!sd) begin
      m_instr = fetched; m_p4 = m_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 1;
    end
    m_pc = npc;
    #1;
    chk_all(tag);
  endtask

  task automatic run(input string tag);
    cyc(0, 0, 0, 0, 32'h0, 0, tag);
  endtask

  // Reset pulse between edges, with a redirect pending; outputs must clear
  // before the next edge.
  task automatic mid_reset();
    branch_taken_d = 1'b1; pc_branch_d = 32'h0000_0400; jump_d = 1'b1;
    #2 rst = 1'b1;
    #1 model_reset();
    chk_all("arst");
    #1 rst = 1'b0;
    branch_taken_d = 1'b0; jump_d = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall_f = 0; stall_d = 0; flush_d = 0;
    branch_taken_d = 0; jump_d = 0; pc_branch_d = 0;
    model_reset();
    #12;
    chk_all("rst");
    rst = 1'b0;

    // Free run over the small program.
    run("fr0");
    chk("fr0.instr_k", instr_d, 32'h2008_0005);
    run("fr1");
    // Stall both stages for 3 cycles at pc 0x8.
    chk("stl.pc_k", pc_f, 32'h8);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 32'h0, 0, "stall");
    chk("stl.cnt_k", fetch_count, 32'd2);
    run("fr2");
    chk("fr2.pc_k", pc_f, 32'hC);
    run("fr3");
    chk("fr3.pc_k", pc_f, 32'h10);
    chk("fr3.cnt_k", fetch_count, 32'd4);
    chk("fr3.instr_k", instr_d, 32'hAC0A_0000);

    // Taken branch with flush at 0x10.
    cyc(0, 0, 1, 1, 32'h40, 0, "br");
    chk("br.pc_k", pc_f, 32'h40);
    chk("br.vld_k", 32'(valid_d), 32'd0);
    run("br1");
    chk("br1.p4_k", pc_plus4_d, 32'h44);

    // Reach 0x1000_0010 (jump word), then jump and branch together.
    cyc(0, 0, 1, 1, 32'h1000_0010, 0, "toj");
    run("ldj");
    cyc(0, 0, 1, 1, 32'h0000_0200, 1, "jmp");
    chk("jmp.pc_k", pc_f, 32'h1000_0080);

    // Flush beats stall on IF/ID.
    run("fs0");
    cyc(0, 1, 1, 0, 32'h0, 0, "fl_st");

    // Misaligned branch target; the flag is sticky.
    cyc(0, 0, 1, 1, 32'h42, 0, "mis");
    chk("mis.pc_k", pc_f, 32'h40);
    run("mis1"); run("mis2");
    chk("mis.err_k", 32'(misalign_err), 32'd1);

    // PC wrap from 0xFFFF_FFFC.
    cyc(0, 0, 1, 1, 32'hFFFF_FFFC, 0, "towrap");
    run("wrap");
    chk("wrap.pc_k", pc_f, 32'h0);

    mid_reset();
    run("postrst");

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic sf, sd, fl, br, jp;
      logic [31:0] tgt;
      sf  = ($urandom_range(0, 5) == 0);
      sd  = ($urandom_range(0, 5) == 0);
      fl  = ($urandom_range(0, 4) == 0);
      br  = ($urandom_range(0, 5) == 0);
      jp  = ($urandom_range(0, 9) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      cyc(sf, sd, fl, br, tgt, jp, "rnd");
      if ($urandom_range(0, 99) == 0) mid_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core.
- Owns the program counter and drives the instruction memory address (pc_f), taking the returned word combinationally as instr_f.
- Registers the fetched word and PC+4 into the IF/ID pipeline register for decode.
- Applies branch/jump redirects, hazard-unit stalls and flushes, and keeps a retired-fetch counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, word placed in instr_d on reset or flush (sll $0,$0,0).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- instr_f  input  32  instruction word read from instruction memory at pc_f.
- stall_f  input  1  hold PC (from hazard unit).
- stall_d  input  1  hold IF/ID register.
- flush_d  input  1  clear IF/ID register to bubble.
- branch_taken_d  input  1  branch resolved taken in decode.
- pc_branch_d  input  32  branch target from decode.
- jump_d  input  1  decode holds a j/jal.
- pc_f  output  32  current PC, instruction memory address.
- instr_d  output  32  IF/ID instruction.
- pc_plus4_d  output  32  IF/ID PC+4.
- valid_d  output  1  instr_d is a real fetched instruction, not a bubble.
- fetch_count  output  32  number of instructions accepted into IF/ID.
- misalign_err  output  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (async, rst=1): pc_f=RESET_PC, instr_d=NOP_INSTR, pc_plus4_d=0, valid_d=0, fetch_count=0, misalign_err=0. All take effect immediately, independent of clk.
- Next-PC select, evaluated every rising edge, priority high to low:
  - stall_f=1: pc_f holds. Redirect inputs are ignored this cycle; the hazard unit keeps them asserted while D is stalled.
  - jump_d=1: pc_f <= {pc_plus4_d[31:28], instr_d[25:0], 2'b00}.
  - branch_taken_d=1: pc_f <= {pc_branch_d[31:2], 2'b00}. If pc_branch_d[1:0] != 0, misalign_err <= 1.
  - Otherwise: pc_f <= pc_f + 4, 32-bit modular arithmetic. 32'hFFFF_FFFC wraps to 0 with no flag.
- jump_d and branch_taken_d both high: jump wins.
- IF/ID register, each rising edge, priority high to low:
  - flush_d=1: instr_d=NOP_INSTR, pc_plus4_d=0, valid_d=0. Flush wins over stall_d.
  - stall_d=1: all IF/ID outputs hold.
  - Otherwise: instr_d<=instr_f, pc_plus4_d<=pc_f+4, valid_d<=1.
- Redirect flush: the block does not self-flush. The hazard unit asserts flush_d together with branch_taken_d/jump_d so the wrong-path fetch becomes a bubble.
- fetch_count: increments by 1 on each edge where the IF/ID load case is taken (no flush, no stall). Wraps at 2^32.
- misalign_err: sticky until reset.
- Latency:
  - pc_f to instr_d: 1 cycle.
  - Redirect: the target appears on pc_f the edge after the redirect input is sampled, and its instruction reaches D one edge later.
- Memory interface is purely combinational; no handshake. instr_f must be valid within the same cycle as pc_f.
- Reset asserted mid-stall or mid-redirect: the reset state is forced immediately, and the pending redirect is lost.
- No combinational path from any input to pc_f. Every output is registered.

Test Plan:
- Reset then 4 free-running cycles, ROM words 0x20080005, 0x20090003, 0x01095020, 0xAC0A0000 → pc_f 0,4,8,C,10. instr_d lags pc_f by 1 cycle. valid_d=1 from cycle 2. fetch_count=4.
- stall_f=stall_d=1 for 3 cycles at pc_f=0x8 → pc_f stays 0x8, instr_d/pc_plus4_d unchanged, fetch_count unchanged. On release, sequence resumes at 0xC.
- branch_taken_d=1, pc_branch_d=0x40, flush_d=1 at pc_f=0x10 → next pc_f=0x40, instr_d=NOP, valid_d=0. The following edge loads the word at 0x40 with pc_plus4_d=0x44.
- jump_d=1 with instr_d=0x08000020 and pc_plus4_d=0x1000_0014, plus branch_taken_d=1 in the same cycle → pc_f=0x1000_0080 (jump wins).
- pc_branch_d=0x42 taken → pc_f=0x40, misalign_err=1 and stays 1 after further fetches. pc_f=0xFFFF_FFFC free-run → pc_f=0. Async rst pulse mid-cycle → all outputs return to reset values before the next edge.
